sliding_window_gen: RTL

SLIDING_WINDOW_GEN -- requirements
Module: sliding_window_gen

---
 rtl/sliding_window_gen_if.sv | 15 +
 rtl/sliding_window_gen.sv | 126 ++++++++++++
 2 files changed

// File: rtl/sliding_window_gen_if.sv
// Pixel-in / window-out bundle for sliding_window_gen.
interface sliding_window_gen_if #(
    parameter int WI = 8,
    parameter int N  = 16
);
    logic            vld_i;
    logic [WI-1:0]   pix_i;
    logic            rdy_o;
    logic [N*WI-1:0] win_o;
    logic            vld_o;
    logic            frame_done;

    modport slave  (input vld_i, pix_i, output rdy_o, win_o, vld_o, frame_done);
    modport master (output vld_i, pix_i, input rdy_o, win_o, vld_o, frame_done);
endinterface

// File: rtl/sliding_window_gen.sv
// Raster-order 3x3 window generator with zero padding at the image borders.
// Emits one window per accepted pixel after the first WIDTH+1, then flushes the last WIDTH+1.
module sliding_window_gen #(
    parameter int WIDTH  = 128,
    parameter int HEIGHT = 128,
    parameter int WI     = 8,
    parameter int N      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    sliding_window_gen_if.slave   bus
);
    localparam int DEPTH = 2*WIDTH + 3;
    localparam int CW    = $clog2(WIDTH*HEIGHT);
    localparam int RW    = $clog2(HEIGHT);
    localparam int CLW   = $clog2(WIDTH);
    localparam int FW    = $clog2(WIDTH+1);

    localparam logic [CW-1:0]  P_RUN  = CW'(WIDTH+1);
    localparam logic [CW-1:0]  P_LAST = CW'(WIDTH*HEIGHT-1);
    localparam logic [RW-1:0]  R_LAST = RW'(HEIGHT-1);
    localparam logic [CLW-1:0] C_LAST = CLW'(WIDTH-1);
    localparam logic [FW-1:0]  F_LAST = FW'(WIDTH);

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

    state_t                      state;
    logic                        rdy_q, vld_q, done_q;
    logic [CW-1:0]               in_cnt;
    logic [FW-1:0]               fl_cnt;
    logic [RW-1:0]               ctr_r;
    logic [CLW-1:0]              ctr_c;
    // The incoming pixel is position 0 of the 2*WIDTH+3 span; only the older positions are stored.
    logic [DEPTH-2:0][WI-1:0]    sr;
    logic [DEPTH-1:0][WI-1:0]    sr_nxt;
    logic [N-1:0][WI-1:0]        win_q, win_nxt;
    logic                        accept, shift, emit;

    assign accept = bus.vld_i && rdy_q && (state != FLUSH);
    assign shift  = accept || (state == FLUSH);
    assign emit   = shift && ((state != FILL) || (in_cnt == P_RUN));
    assign sr_nxt = {sr, (state == FLUSH) ? {WI{1'b0}} : bus.pix_i};

    // Tap k of a row sits WIDTH positions further back than the same tap one row below.
    always_comb begin
        logic top, bot, lft, rgt;
        win_nxt = '0;
        top = (ctr_r != '0);
        bot = (ctr_r != R_LAST);
        lft = (ctr_c != '0);
        rgt = (ctr_c != C_LAST);
        if (top && lft) win_nxt[0] = sr_nxt[2*WIDTH+2];
        if (top)        win_nxt[1] = sr_nxt[2*WIDTH+1];
        if (top && rgt) win_nxt[2] = sr_nxt[2*WIDTH];
        if (lft)        win_nxt[3] = sr_nxt[WIDTH+2];
        win_nxt[4] = sr_nxt[WIDTH+1];
        if (rgt)        win_nxt[5] = sr_nxt[WIDTH];
        if (bot && lft) win_nxt[6] = sr_nxt[2];
        if (bot)        win_nxt[7] = sr_nxt[1];
        if (bot && rgt) win_nxt[8] = sr_nxt[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= FILL;
            rdy_q  <= 1'b0;
            vld_q  <= 1'b0;
            done_q <= 1'b0;
            in_cnt <= '0;
            fl_cnt <= '0;
            ctr_r  <= '0;
            ctr_c  <= '0;
            sr     <= '0;
            win_q  <= '0;
        end else begin
            vld_q  <= 1'b0;
            done_q <= 1'b0;
            if (shift) sr <= sr_nxt[DEPTH-2:0];
            if (emit) begin
                win_q <= win_nxt;
                vld_q <= 1'b1;
                if (ctr_c == C_LAST) begin
                    ctr_c <= '0;
                    ctr_r <= (ctr_r == R_LAST) ? '0 : ctr_r + 1'b1;
                end else begin
                    ctr_c <= ctr_c + 1'b1;
                end
            end
            case (state)
                FILL: begin
                    rdy_q <= 1'b1;
                    if (accept) begin
                        in_cnt <= in_cnt + 1'b1;
                        if (in_cnt == P_RUN) state <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (in_cnt == P_LAST) begin
                            state  <= FLUSH;
                            rdy_q  <= 1'b0;
                            in_cnt <= '0;
                            fl_cnt <= '0;
                        end else begin
                            in_cnt <= in_cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    fl_cnt <= fl_cnt + 1'b1;
                    if (fl_cnt == F_LAST) begin
                        state  <= FILL;
                        rdy_q  <= 1'b1;
                        done_q <= 1'b1;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign bus.rdy_o      = rdy_q;
    assign bus.vld_o      = vld_q;
    assign bus.frame_done = done_q;
    assign bus.win_o      = win_q;
endmodule
